maxpool_relu_yt: RTL and testbench

- Post-processing stage directly downstream of conv_yt.
- Reads the convolution result feature map out of the output BRAM that conv_yt fills (M1 side), applies ReLU and 2x2 stride-2 max pooling, and writes the pooled map into a further bram_sim instance.
- Starts on a one-cycle start pulse, typically issued when conv_yt raises finish; signals completion with finish.
- Uses the same single-port BRAM request interface as conv_yt: read master on the source BRAM, write master on the destination BRAM.

---
 rtl/yt_pkg.sv | 25 ++
 rtl/maxpool_relu_yt_if.sv | 29 ++
 rtl/maxpool_relu_yt_addr.sv | 84 ++++++++
 rtl/maxpool_relu_yt.sv | 127 ++++++++++++
 tb/tb_maxpool_relu_yt.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/yt_pkg.sv
// Shared widths, FSM encoding and address helper for the yt post-processing stages.
package yt_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WREQ_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    RD3,
    LAST,
    WR,
    DONE
  } state_t;

  // Word index to byte-style port address.
  function automatic logic [ADDR_W-1:0] word_to_addr(input logic [ADDR_W-1:0] word,
                                                     input int unsigned shift);
    return word << shift;
  endfunction

endpackage

// File: rtl/maxpool_relu_yt_if.sv
// Source (S_*) and destination (D_*) single-port BRAM request signals.
interface maxpool_relu_yt_if;
  import yt_pkg::*;

  logic              S_R_req;
  logic [ADDR_W-1:0] S_addr;
  logic [DATA_W-1:0] S_R_data;
  logic [WREQ_W-1:0] S_W_req;
  logic [DATA_W-1:0] S_W_data;

  logic              D_R_req;
  logic [ADDR_W-1:0] D_addr;
  logic [DATA_W-1:0] D_R_data;
  logic [WREQ_W-1:0] D_W_req;
  logic [DATA_W-1:0] D_W_data;

  modport master (
    output S_R_req, S_addr, S_W_req, S_W_data,
    output D_R_req, D_addr, D_W_req, D_W_data,
    input  S_R_data, D_R_data
  );

  modport slave (
    input  S_R_req, S_addr, S_W_req, S_W_data,
    input  D_R_req, D_addr, D_W_req, D_W_data,
    output S_R_data, D_R_data
  );

endinterface

// File: rtl/maxpool_relu_yt_addr.sv
// Channel/row/column walk over the pooled map; yields read and write word indices.
module pool_addr_gen import yt_pkg::*; #(
  parameter int unsigned IN_W = 26,
  parameter int unsigned IN_H = 26,
  parameter int unsigned CH   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              step,
  input  logic [1:0]        rd_sel,
  output logic [ADDR_W-1:0] rd_word,
  output logic [ADDR_W-1:0] wr_word,
  output logic              last
);

  localparam int unsigned OUT_W = IN_W / 2;
  localparam int unsigned OUT_H = IN_H / 2;

  // Wrap limits clamp to 0 for degenerate sizes; the top never walks in that case.
  localparam logic [ADDR_W-1:0] OX_MAX    = (OUT_W > 0) ? ADDR_W'(OUT_W - 1) : '0;
  localparam logic [ADDR_W-1:0] OY_MAX    = (OUT_H > 0) ? ADDR_W'(OUT_H - 1) : '0;
  localparam logic [ADDR_W-1:0] C_MAX     = (CH > 0)    ? ADDR_W'(CH - 1)    : '0;
  localparam logic [ADDR_W-1:0] IN_W_L    = ADDR_W'(IN_W);
  localparam logic [ADDR_W-1:0] OUT_W_L   = ADDR_W'(OUT_W);
  localparam logic [ADDR_W-1:0] IN_PLANE  = ADDR_W'(IN_W * IN_H);
  localparam logic [ADDR_W-1:0] OUT_PLANE = ADDR_W'(OUT_W * OUT_H);

  logic [ADDR_W-1:0] c_q, c_d;
  logic [ADDR_W-1:0] oy_q, oy_d;
  logic [ADDR_W-1:0] ox_q, ox_d;
  logic [ADDR_W-1:0] origin;
  logic [ADDR_W-1:0] rd_off;

  always_comb begin
    c_d  = c_q;
    oy_d = oy_q;
    ox_d = ox_q;
    if (restart) begin
      c_d  = '0;
      oy_d = '0;
      ox_d = '0;
    end else if (step) begin
      if (ox_q == OX_MAX) begin
        ox_d = '0;
        if (oy_q == OY_MAX) begin
          oy_d = '0;
          c_d  = (c_q == C_MAX) ? '0 : c_q + 32'd1;
        end else begin
          oy_d = oy_q + 32'd1;
        end
      end else begin
        ox_d = ox_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q  <= '0;
      oy_q <= '0;
      ox_q <= '0;
    end else begin
      c_q  <= c_d;
      oy_q <= oy_d;
      ox_q <= ox_d;
    end
  end

  always_comb begin
    origin = c_q * IN_PLANE + ((oy_q * IN_W_L) << 1) + (ox_q << 1);
    case (rd_sel)
      2'd0:    rd_off = '0;
      2'd1:    rd_off = 32'd1;
      2'd2:    rd_off = IN_W_L;
      default: rd_off = IN_W_L + 32'd1;
    endcase
    rd_word = origin + rd_off;
    wr_word = c_q * OUT_PLANE + oy_q * OUT_W_L + ox_q;
  end

  assign last = (ox_q == OX_MAX) && (oy_q == OY_MAX) && (c_q == C_MAX);

endmodule

// File: rtl/maxpool_relu_yt.sv
// ReLU + 2x2/2 max pooling from the conv output BRAM into a destination BRAM.
module maxpool_relu_yt import yt_pkg::*; #(
  parameter int unsigned IN_W       = 26,
  parameter int unsigned IN_H       = 26,
  parameter int unsigned CH         = 1,
  parameter int unsigned SRC_BASE   = 0,
  parameter int unsigned DST_BASE   = 0,
  parameter int unsigned ADDR_SHIFT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic finish,
  maxpool_relu_yt_if.master bus
);

  localparam bit ZERO_OUT = (IN_W < 2) || (IN_H < 2) || (CH == 0);
  localparam logic [ADDR_W-1:0] SRC_B = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_B = ADDR_W'(DST_BASE);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] acc_max;
  logic              restart;
  logic              step;
  logic              last;
  logic [1:0]        rd_sel;
  logic [ADDR_W-1:0] rd_word;
  logic [ADDR_W-1:0] wr_word;
  logic              unused_d_r_data;

  pool_addr_gen #(
    .IN_W (IN_W),
    .IN_H (IN_H),
    .CH   (CH)
  ) u_addr (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .step    (step),
    .rd_sel  (rd_sel),
    .rd_word (rd_word),
    .wr_word (wr_word),
    .last    (last)
  );

  assign acc_max = ($signed(bus.S_R_data) > $signed(acc_q)) ? bus.S_R_data : acc_q;

  assign bus.S_W_req  = '0;
  assign bus.S_W_data = '0;
  assign bus.D_R_req  = 1'b0;
  assign unused_d_r_data = ^bus.D_R_data;

  // Read data lags its request by one cycle, so each state folds in the word
  // requested by the previous one; LAST absorbs the fourth word.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    restart      = 1'b0;
    step         = 1'b0;
    rd_sel       = 2'd0;
    finish       = 1'b0;
    bus.S_R_req  = 1'b0;
    bus.S_addr   = '0;
    bus.D_W_req  = '0;
    bus.D_addr   = '0;
    bus.D_W_data = '0;
    case (state_q)
      IDLE, DONE: begin
        finish = (state_q == DONE);
        if (start) begin
          restart = 1'b1;
          state_d = ZERO_OUT ? DONE : RD0;
        end
      end
      RD0: begin
        bus.S_R_req = 1'b1;
        rd_sel      = 2'd0;
        state_d     = RD1;
      end
      RD1: begin
        bus.S_R_req = 1'b1;
        rd_sel      = 2'd1;
        acc_d       = bus.S_R_data;
        state_d     = RD2;
      end
      RD2: begin
        bus.S_R_req = 1'b1;
        rd_sel      = 2'd2;
        acc_d       = acc_max;
        state_d     = RD3;
      end
      RD3: begin
        bus.S_R_req = 1'b1;
        rd_sel      = 2'd3;
        acc_d       = acc_max;
        state_d     = LAST;
      end
      LAST: begin
        acc_d   = acc_max;
        state_d = WR;
      end
      WR: begin
        bus.D_W_req  = '1;
        bus.D_addr   = word_to_addr(DST_B + wr_word, ADDR_SHIFT);
        bus.D_W_data = acc_q[DATA_W-1] ? '0 : acc_q;
        step         = 1'b1;
        state_d      = last ? DONE : RD0;
      end
      default: state_d = IDLE;
    endcase
    if (bus.S_R_req) begin
      bus.S_addr = word_to_addr(SRC_B + rd_word, ADDR_SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_maxpool_relu_yt.sv
// Bench: three instances (4x4x1, 5x5x1, 4x4x2) sharing clock/reset, scoreboarded writes.
module tb_maxpool_relu_yt;

  typedef struct {
    int unsigned inst;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_r  [3];
  logic        fin_m    [3];
  logic        s_req_m  [3];
  logic [31:0] s_addr_m [3];
  logic [3:0]  s_wreq_m [3];
  logic [31:0] s_wdata_m[3];
  logic        d_rreq_m [3];
  logic [3:0]  d_wreq_m [3];
  logic [31:0] d_addr_m [3];
  logic [31:0] d_data_m [3];
  logic [31:0] src_mem  [3][64];

  exp_t exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int unsigned W = (g == 1) ? 5 : 4;
    localparam int unsigned C = (g == 2) ? 2 : 1;

    maxpool_relu_yt_if bus ();

    maxpool_relu_yt #(
      .IN_W (W),
      .IN_H (W),
      .CH   (C)
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start_r[g]),
      .finish (fin_m[g]),
      .bus    (bus)
    );

    always @(posedge clk)
      bus.S_R_data <= bus.S_R_req ? src_mem[g][bus.S_addr[7:2]] : 32'hDEADBEEF;
    assign bus.D_R_data = '0;

    assign s_req_m[g]   = bus.S_R_req;
    assign s_addr_m[g]  = bus.S_addr;
    assign s_wreq_m[g]  = bus.S_W_req;
    assign s_wdata_m[g] = bus.S_W_data;
    assign d_rreq_m[g]  = bus.D_R_req;
    assign d_wreq_m[g]  = bus.D_W_req;
    assign d_addr_m[g]  = bus.D_addr;
    assign d_data_m[g]  = bus.D_W_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic push(input int unsigned g, input int unsigned word, input logic [31:0] data);
    exp_t e;
    e.inst = g;
    e.addr = word << 2;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push4(input int unsigned g, input int unsigned base,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    push(g, base, a);
    push(g, base + 1, b);
    push(g, base + 2, c);
    push(g, base + 3, d);
  endtask

  task automatic load_ramp(input int unsigned g, input int unsigned n, input int unsigned offs);
    for (int unsigned i = 0; i < n; i++) src_mem[g][i] = i + offs;
  endtask

  // Pulse start, then count cycles until finish; poke adds a stray start mid-run.
  task automatic run_inst(input int unsigned g, input int unsigned exp_cyc, input bit poke);
    int unsigned n;
    @(posedge clk); #1 start_r[g] = 1'b1;
    @(posedge clk); #1 start_r[g] = 1'b0;
    n = 0;
    while (!fin_m[g] && n < 1000) begin
      @(posedge clk); #1;
      n++;
      start_r[g] = poke && (n == 8);
    end
    start_r[g] = 1'b0;
    check($sformatf("run_cycles_inst%0d", g), n, exp_cyc);
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("drain_inst%0d", g), exp_q.size(), 0);
    check($sformatf("finish_held_inst%0d", g), {31'b0, fin_m[g]}, 1);
  endtask

  initial begin
    rst = 1'b1;
    for (int unsigned g = 0; g < 3; g++) begin
      start_r[g] = 1'b0;
      for (int unsigned i = 0; i < 64; i++) src_mem[g][i] = '0;
    end

    fork
      forever begin
        logic [31:0] w;
        exp_t e;
        @(negedge clk);
        for (int unsigned g = 0; g < 3; g++) begin
          if (g == 1 && s_req_m[g]) begin
            w = s_addr_m[g] >> 2;
            check("rd_row_col_5x5", {30'b0, (w % 5) == 4, (w / 5) == 4}, 0);
          end
          if (d_wreq_m[g] != '0) begin
            check("wr_be", {28'b0, d_wreq_m[g]}, 32'hF);
            check("port_excl", {31'b0, s_req_m[g]}, 0);
            check("tied_off", s_wdata_m[g] | {27'b0, d_rreq_m[g], s_wreq_m[g]}, 0);
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_write inst%0d: got addr 0x%08h data 0x%08h, required no write",
                       g, d_addr_m[g], d_data_m[g]);
            end else begin
              e = exp_q.pop_front();
              check("wr_inst", g, e.inst);
              check("wr_addr", d_addr_m[g], e.addr);
              check("wr_data", d_data_m[g], e.data);
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_finish", {29'b0, fin_m[0], fin_m[1], fin_m[2]}, 0);
    check("rst_s_r_req", {31'b0, s_req_m[0]}, 0);
    check("rst_s_addr", s_addr_m[0], 0);
    check("rst_d_w_req", {28'b0, d_wreq_m[0]}, 0);
    check("rst_d_addr", d_addr_m[0], 0);
    check("rst_d_w_data", d_data_m[0], 0);
    rst = 1'b0;

    // 4x4 ramp
    load_ramp(0, 16, 0);
    push4(0, 0, 5, 7, 13, 15);
    run_inst(0, 24, 1'b0);

    // all -5: signed compare, ReLU clamps to zero
    for (int unsigned i = 0; i < 16; i++) src_mem[0][i] = 32'hFFFF_FFFB;
    push4(0, 0, 0, 0, 0, 0);
    run_inst(0, 24, 1'b0);

    // signed extremes per window
    for (int unsigned i = 0; i < 16; i++) src_mem[0][i] = '0;
    src_mem[0][0]  = 32'h8000_0000;
    src_mem[0][1]  = 32'h0000_0001;
    src_mem[0][4]  = 32'h7FFF_FFFF;
    src_mem[0][5]  = 32'hFFFF_FFFF;
    src_mem[0][2]  = 32'hFFFF_FFFF;
    src_mem[0][3]  = 32'hFFFF_FFFE;
    src_mem[0][6]  = 32'hFFFF_FFFD;
    src_mem[0][7]  = 32'hFFFF_FFFC;
    src_mem[0][8]  = 32'h0000_0003;
    src_mem[0][9]  = 32'h7FFF_FFFE;
    src_mem[0][12] = 32'hFFFF_FF9C;
    src_mem[0][13] = 32'h0000_0009;
    push4(0, 0, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFE, 0);
    run_inst(0, 24, 1'b0);

    // 5x5: last row/column (set large) must be ignored
    load_ramp(1, 25, 0);
    for (int unsigned i = 0; i < 5; i++) begin
      src_mem[1][i * 5 + 4] = 1000;
      src_mem[1][20 + i]    = 1000;
    end
    push4(1, 0, 6, 8, 16, 18);
    run_inst(1, 24, 1'b0);

    // two planes, plane1 = plane0 + 100
    load_ramp(2, 16, 0);
    for (int unsigned i = 0; i < 16; i++) src_mem[2][16 + i] = i + 100;
    push4(2, 0, 5, 7, 13, 15);
    push4(2, 4, 105, 107, 113, 115);
    run_inst(2, 48, 1'b0);

    // reset at cycle 10: only pixel 0 is written before the abort
    load_ramp(0, 16, 0);
    push(0, 0, 5);
    @(posedge clk); #1 start_r[0] = 1'b1;
    @(posedge clk); #1 start_r[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_finish", {31'b0, fin_m[0]}, 0);
    check("abort_s_r_req", {31'b0, s_req_m[0]}, 0);
    check("abort_s_addr", s_addr_m[0], 0);
    check("abort_d_w_req", {28'b0, d_wreq_m[0]}, 0);
    check("abort_d_addr", d_addr_m[0], 0);
    check("abort_d_w_data", d_data_m[0], 0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_drain", exp_q.size(), 0);

    // fresh run after abort, then a run with a stray mid-run start
    push4(0, 0, 5, 7, 13, 15);
    run_inst(0, 24, 1'b0);
    push4(0, 0, 5, 7, 13, 15);
    run_inst(0, 24, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
